shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_arbiter_if.sv | 40 ++++
 rtl/right_shifter.sv | 18 +
 rtl/shift_arbiter.sv | 80 ++++++++
 tb/tb_shift_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and default widths for the shift arbiter slice.
// The request struct bundles one requester's operands as seen by the datapath.
package shift_pkg;

  localparam int XLEN = 64;
  localparam int SHW  = 6;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [SHW-1:0]  b;
    logic            sra;
  } shift_req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two-requester shift bus: r0 is the integer ALU, r1 the FPU mantissa aligner.
// master = requester side, slave = arbiter side.
interface shift_arbiter_if #(
  parameter int XLEN = shift_pkg::XLEN,
  parameter int SHW  = shift_pkg::SHW
);

  logic            r0_req_valid;
  logic            r0_req_ready;
  logic [XLEN-1:0] r0_a;
  logic [SHW-1:0]  r0_b;
  logic            r0_sra;
  logic            r0_resp_valid;
  logic            r0_resp_ready;
  logic [XLEN-1:0] r0_s;

  logic            r1_req_valid;
  logic            r1_req_ready;
  logic [XLEN-1:0] r1_a;
  logic [SHW-1:0]  r1_b;
  logic            r1_sra;
  logic            r1_resp_valid;
  logic            r1_resp_ready;
  logic [XLEN-1:0] r1_s;

  modport master (
    output r0_req_valid, r0_a, r0_b, r0_sra, r0_resp_ready,
    output r1_req_valid, r1_a, r1_b, r1_sra, r1_resp_ready,
    input  r0_req_ready, r0_resp_valid, r0_s,
    input  r1_req_ready, r1_resp_valid, r1_s
  );

  modport slave (
    input  r0_req_valid, r0_a, r0_b, r0_sra, r0_resp_ready,
    input  r1_req_valid, r1_a, r1_b, r1_sra, r1_resp_ready,
    output r0_req_ready, r0_resp_valid, r0_s,
    output r1_req_ready, r1_resp_valid, r1_s
  );

endinterface

// File: rtl/right_shifter.sv
// Combinational right shifter: logical when sra=0, arithmetic when sra=1.
// The shift amount is treated as an unsigned (zero-extended) count.
module right_shifter #(
  parameter int XLEN = 64,
  parameter int SHW  = 6
) (
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  b,
  input  logic            sra,
  output logic [XLEN-1:0] s
);

  always_comb begin
    if (sra) s = XLEN'($signed(a) >>> b);
    else     s = a >> b;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one right_shifter between two requesters,
// with a single registered result slot that can drain and refill in one cycle.
module shift_arbiter #(
  parameter int XLEN = shift_pkg::XLEN,
  parameter int SHW  = shift_pkg::SHW
) (
  input  logic            clk,
  input  logic            reset,
  shift_arbiter_if.slave  bus
);

  import shift_pkg::*;

  state_t          state;
  logic            owner;
  logic            prio;
  logic [XLEN-1:0] r0_s_q;
  logic [XLEN-1:0] r1_s_q;

  logic            owner_ready;
  logic            can_accept;
  logic            gnt0;
  logic            gnt1;
  logic [XLEN-1:0] op_a;
  logic [SHW-1:0]  op_b;
  logic            op_sra;
  logic [XLEN-1:0] shifted;

  // NOTE: every signal is assigned on every pass through this block, so no latches are inferred.
  always_comb begin
    owner_ready = owner ? bus.r1_resp_ready : bus.r0_resp_ready;
    can_accept  = !reset && (state == EMPTY || owner_ready);
    gnt0        = can_accept && bus.r0_req_valid && (!bus.r1_req_valid || !prio);
    gnt1        = can_accept && bus.r1_req_valid && (!bus.r0_req_valid ||  prio);
  end

  assign op_a   = gnt1 ? bus.r1_a   : bus.r0_a;
  assign op_b   = gnt1 ? bus.r1_b   : bus.r0_b;
  assign op_sra = gnt1 ? bus.r1_sra : bus.r0_sra;

  right_shifter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shifter (
    .a   (op_a),
    .b   (op_b),
    .sra (op_sra),
    .s   (shifted)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      owner  <= 1'b0;
      prio   <= 1'b0;
      r0_s_q <= '0;
      r1_s_q <= '0;
    end else if (gnt0 || gnt1) begin
      // A grant always lands in FULL, whether from EMPTY or a same-cycle drain.
      state  <= FULL;
      owner  <= gnt1;
      prio   <= gnt0;
      r0_s_q <= gnt0 ? shifted : '0;
      r1_s_q <= gnt1 ? shifted : '0;
    end else if (state == FULL && owner_ready) begin
      state  <= EMPTY;
      r0_s_q <= '0;
      r1_s_q <= '0;
    end
  end

  assign bus.r0_req_ready  = gnt0;
  assign bus.r1_req_ready  = gnt1;
  assign bus.r0_resp_valid = (state == FULL) && !owner;
  assign bus.r1_resp_valid = (state == FULL) &&  owner;
  assign bus.r0_s          = r0_s_q;
  assign bus.r1_s          = r1_s_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios with literal results,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_arbiter_if bus ();

  shift_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference shift built from a plain logical shift plus explicit sign fill.
  function automatic logic [63:0] ref_shift(input logic [63:0] a, input int b, input bit sra);
    logic [63:0] ones;
    logic [63:0] r;
    ones = '1;
    r    = a >> b;
    if (sra && a[63]) r = r | ~(ones >> b);
    return r;
  endfunction

  // Transaction-level model: who holds the single result slot, its value, and the turn pointer.
  int          m_held = -1;
  int          m_prio = 0;
  logic [63:0] m_val  = '0;
  bit          started = 0;
  int          dut_deliv0 = 0;
  int          dut_deliv1 = 0;

  function automatic int exp_grant();
    bit free;
    if (reset) return -1;
    free = (m_held < 0) || (m_held == 0 && bus.r0_resp_ready) || (m_held == 1 && bus.r1_resp_ready);
    if (!free) return -1;
    if (bus.r0_req_valid && bus.r1_req_valid) return m_prio;
    if (bus.r0_req_valid) return 0;
    if (bus.r1_req_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_grant();
    if (reset) begin
      m_held = -1;
      m_prio = 0;
      m_val  = '0;
    end else begin
      if ((m_held == 0 && bus.r0_resp_ready) || (m_held == 1 && bus.r1_resp_ready)) m_held = -1;
      if (g == 0) m_val = ref_shift(bus.r0_a, int'(bus.r0_b), bus.r0_sra);
      if (g == 1) m_val = ref_shift(bus.r1_a, int'(bus.r1_b), bus.r1_sra);
      if (g >= 0) begin
        m_held = g;
        m_prio = 1 - g;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (started) begin
      g = exp_grant();
      check("r0_req_ready",  64'(bus.r0_req_ready),  64'(g == 0));
      check("r1_req_ready",  64'(bus.r1_req_ready),  64'(g == 1));
      check("r0_resp_valid", 64'(bus.r0_resp_valid), 64'(m_held == 0));
      check("r1_resp_valid", 64'(bus.r1_resp_valid), 64'(m_held == 1));
      check("r0_s", bus.r0_s, (m_held == 0) ? m_val : 64'h0);
      check("r1_s", bus.r1_s, (m_held == 1) ? m_val : 64'h0);
      if (bus.r0_resp_valid && bus.r0_resp_ready) dut_deliv0++;
      if (bus.r1_resp_valid && bus.r1_resp_ready) dut_deliv1++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  issued0;
    int  issued1;
    int  cyc;
    bit  fire0;
    bit  fire1;

    reset = 1'b1;
    bus.r0_req_valid = 1'b1; bus.r0_a = 64'h1; bus.r0_b = '0; bus.r0_sra = 1'b0; bus.r0_resp_ready = 1'b1;
    bus.r1_req_valid = 1'b1; bus.r1_a = 64'h2; bus.r1_b = '0; bus.r1_sra = 1'b0; bus.r1_resp_ready = 1'b1;
    @(posedge clk);
    started = 1;

    // Reset held with both requesters pending: nothing granted, nothing held.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_r0_ready", 64'(bus.r0_req_ready), 64'h0);
      check("rst_r1_ready", 64'(bus.r1_req_ready), 64'h0);
      check("rst_r0_valid", 64'(bus.r0_resp_valid), 64'h0);
      check("rst_r0_s", bus.r0_s, 64'h0);
      if (i == 0) @(posedge clk);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    check("first_gnt_r0", 64'(bus.r0_req_ready), 64'h1);
    check("first_gnt_r1", 64'(bus.r1_req_ready), 64'h0);
    step();
    bus.r0_req_valid = 1'b0; bus.r1_req_valid = 1'b0;
    @(negedge clk);
    check("first_resp_s", bus.r0_s, 64'h1);

    // Arithmetic shift of the most negative value by 63 fills with ones.
    step();
    bus.r0_req_valid = 1'b1; bus.r0_a = 64'h8000_0000_0000_0000; bus.r0_b = 6'd63; bus.r0_sra = 1'b1;
    step();
    bus.r0_req_valid = 1'b0;
    @(negedge clk);
    check("sra_valid", 64'(bus.r0_resp_valid), 64'h1);
    check("sra_s", bus.r0_s, 64'hFFFF_FFFF_FFFF_FFFF);

    // Logical shift on r1; r0 must stay idle.
    step();
    bus.r1_req_valid = 1'b1; bus.r1_a = 64'hF000_0000_0000_00F0; bus.r1_b = 6'd4; bus.r1_sra = 1'b0;
    step();
    bus.r1_req_valid = 1'b0;
    @(negedge clk);
    check("srl_s", bus.r1_s, 64'h0F00_0000_0000_000F);
    check("srl_r0_idle", 64'(bus.r0_resp_valid), 64'h0);

    // Contention: grants alternate and results arrive back-to-back.
    step();
    bus.r0_req_valid = 1'b1; bus.r0_a = 64'h11; bus.r0_b = '0; bus.r0_sra = 1'b0;
    bus.r1_req_valid = 1'b1; bus.r1_a = 64'h22; bus.r1_b = '0; bus.r1_sra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_gnt0", 64'(bus.r0_req_ready), 64'(i % 2 == 0));
      check("rr_gnt1", 64'(bus.r1_req_ready), 64'(i % 2 == 1));
      if (i > 0) check("rr_b2b", 64'((i % 2 == 1) ? bus.r0_resp_valid : bus.r1_resp_valid), 64'h1);
      step();
    end
    bus.r0_req_valid = 1'b0; bus.r1_req_valid = 1'b0;
    @(negedge clk);
    check("rr_last_s", bus.r1_s, 64'h22);

    // Backpressure on r0 while r1 waits; release drains and refills in one cycle.
    step();
    bus.r0_req_valid = 1'b1; bus.r0_a = 64'hDEAD_BEEF_0000_1234; bus.r0_b = 6'd8; bus.r0_sra = 1'b1;
    bus.r0_resp_ready = 1'b0;
    step();
    bus.r0_req_valid = 1'b0;
    bus.r1_req_valid = 1'b1; bus.r1_a = 64'h0123_4567_89AB_CDEF; bus.r1_b = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_r0_s", bus.r0_s, 64'hFFDE_ADBE_EF00_0012);
      check("bp_r1_ready", 64'(bus.r1_req_ready), 64'h0);
      step();
      if (i < 2) bus.r0_a = bus.r0_a ^ 64'hFFFF;
    end
    bus.r0_resp_ready = 1'b1;
    @(negedge clk);
    check("bp_refill_gnt", 64'(bus.r1_req_ready), 64'h1);
    step();
    bus.r1_req_valid = 1'b0;
    @(negedge clk);
    check("bp_r1_s", bus.r1_s, 64'h0123_4567_89AB_CDEF);
    check("bp_r0_idle", 64'(bus.r0_resp_valid), 64'h0);
    step();

    // Randomized traffic with stalls on both sides; the compare process does the checking.
    dut_deliv0 = 0; dut_deliv1 = 0;
    issued0 = 0; issued1 = 0; cyc = 0;
    while ((issued0 < 500 || issued1 < 500) && cyc < 20000) begin
      @(negedge clk);
      fire0 = bus.r0_req_valid && bus.r0_req_ready;
      fire1 = bus.r1_req_valid && bus.r1_req_ready;
      step();
      cyc++;
      if (fire0) begin issued0++; bus.r0_req_valid = 1'b0; end
      if (fire1) begin issued1++; bus.r1_req_valid = 1'b0; end
      if (!bus.r0_req_valid) begin
        bus.r0_a = {$urandom(), $urandom()}; bus.r0_b = 6'($urandom_range(63)); bus.r0_sra = 1'($urandom_range(1));
        if (issued0 < 500 && $urandom_range(3) != 0) bus.r0_req_valid = 1'b1;
      end
      if (!bus.r1_req_valid) begin
        bus.r1_a = {$urandom(), $urandom()}; bus.r1_b = 6'($urandom_range(63)); bus.r1_sra = 1'($urandom_range(1));
        if (issued1 < 500 && $urandom_range(3) != 0) bus.r1_req_valid = 1'b1;
      end
      bus.r0_resp_ready = ($urandom_range(9) < 7);
      bus.r1_resp_ready = ($urandom_range(9) < 7);
    end
    bus.r0_req_valid = 1'b0; bus.r1_req_valid = 1'b0;
    bus.r0_resp_ready = 1'b1; bus.r1_resp_ready = 1'b1;
    repeat (3) step();
    check("rand_no_timeout", 64'(cyc < 20000), 64'h1);
    check("rand_deliv_r0", 64'(dut_deliv0), 64'(issued0));
    check("rand_deliv_r1", 64'(dut_deliv1), 64'(issued1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
